bsg_fifo_1rw_bank_sched: RTL

- Control/scheduling engine for a two-bank large FIFO.
- Each bank is a 1RW SRAM (big FIFO) feeding a 2-element small FIFO.
- The block owns all pointers, counts and small-FIFO credits. It decides, per bank per cycle, between: SRAM write, SRAM read (transfer to small FIFO), or direct bypass into the small FIFO.
- Surrounding datapath: input data fans out to both banks; small-FIFO outputs are drained by an external round-robin N-to-1. This block only sequences that datapath.

---
 rtl/bsg_fifo_1rw_bank_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bsg_fifo_1rw_bank_sched.sv
// Scheduler for a two-bank 1RW-SRAM FIFO where each bank feeds a 2-entry small FIFO.
// Owns pointers, counts and small-FIFO credits; picks bypass, write or read per bank per cycle.
module bsg_fifo_1rw_bank_sched #(
  parameter int unsigned els_p = 64,
  localparam int unsigned lg_bank_els_lp = (els_p / 2 > 1) ? $clog2(els_p / 2) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_o,
  output logic                        wr_bank_o,
  output logic [1:0]                  bank_v_o,
  output logic [1:0]                  bank_w_o,
  output logic [2*lg_bank_els_lp-1:0] bank_addr_o,
  output logic [1:0]                  sf_enq_o,
  output logic [1:0]                  sf_src_o,
  input  logic [1:0]                  sf_deq_i
);

  localparam int unsigned BankEls = els_p / 2;
  localparam int unsigned CntW    = $clog2(BankEls + 1);

  typedef logic [lg_bank_els_lp-1:0] addr_t;
  typedef logic [CntW-1:0]           cnt_t;

  localparam addr_t LastAddr = addr_t'(BankEls - 1);
  localparam cnt_t  CntFull  = cnt_t'(BankEls);

  logic       wr_bank_q, wr_bank_d;
  addr_t      wptr_q   [2];
  addr_t      wptr_d   [2];
  addr_t      rptr_q   [2];
  addr_t      rptr_d   [2];
  cnt_t       cnt_q    [2];
  cnt_t       cnt_d    [2];
  logic [1:0] credit_q [2];
  logic [1:0] credit_d [2];
  logic [1:0] inflight_q, inflight_d;

  logic       acc;
  logic [1:0] byp_ok, arr, do_byp, do_wr, do_rd, issue;

  function automatic addr_t ptr_inc(input addr_t p);
    return (p == LastAddr) ? '0 : p + addr_t'(1);
  endfunction

  assign wr_bank_o = wr_bank_q;

  always_comb begin
    byp_ok      = '0;
    arr         = '0;
    do_byp      = '0;
    do_wr       = '0;
    do_rd       = '0;
    issue       = '0;
    bank_v_o    = '0;
    bank_w_o    = '0;
    bank_addr_o = '0;
    sf_enq_o    = '0;
    sf_src_o    = '0;
    inflight_d  = '0;
    for (int b = 0; b < 2; b++) begin
      wptr_d[b]   = wptr_q[b];
      rptr_d[b]   = rptr_q[b];
      cnt_d[b]    = cnt_q[b];
      credit_d[b] = credit_q[b];
      byp_ok[b]   = (cnt_q[b] == '0) && !inflight_q[b] && (credit_q[b] != 2'd0);
    end

    // Ready looks only at state so the upstream can't form a combinational loop through v_i.
    ready_o   = !reset_i && (byp_ok[wr_bank_q] || (cnt_q[wr_bank_q] != CntFull));
    acc       = v_i && ready_o;
    wr_bank_d = wr_bank_q ^ acc;

    for (int b = 0; b < 2; b++) begin
      arr[b]    = acc && (wr_bank_q == b[0]);
      do_byp[b] = arr[b] && byp_ok[b];
      do_wr[b]  = arr[b] && !byp_ok[b];
      do_rd[b]  = !reset_i && !arr[b] && (cnt_q[b] != '0) && (credit_q[b] != 2'd0);
      issue[b]  = do_byp[b] || do_rd[b];

      bank_v_o[b] = do_wr[b] || do_rd[b];
      bank_w_o[b] = do_wr[b];
      bank_addr_o[b*lg_bank_els_lp +: lg_bank_els_lp] = do_wr[b] ? wptr_q[b] : rptr_q[b];

      // A read returns one cycle later; bypass never overlaps it, so one enqueue per cycle.
      sf_enq_o[b] = !reset_i && (do_byp[b] || inflight_q[b]);
      sf_src_o[b] = inflight_q[b];

      if (do_wr[b]) begin
        wptr_d[b] = ptr_inc(wptr_q[b]);
        cnt_d[b]  = cnt_q[b] + cnt_t'(1);
      end else if (do_rd[b]) begin
        rptr_d[b] = ptr_inc(rptr_q[b]);
        cnt_d[b]  = cnt_q[b] - cnt_t'(1);
      end

      if (sf_deq_i[b] && !issue[b]) begin
        credit_d[b] = credit_q[b] + 2'd1;
      end else if (!sf_deq_i[b] && issue[b]) begin
        credit_d[b] = credit_q[b] - 2'd1;
      end

      inflight_d[b] = do_rd[b];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_bank_q  <= 1'b0;
      inflight_q <= '0;
      for (int b = 0; b < 2; b++) begin
        wptr_q[b]   <= '0;
        rptr_q[b]   <= '0;
        cnt_q[b]    <= '0;
        credit_q[b] <= 2'd2;
      end
    end else begin
      wr_bank_q  <= wr_bank_d;
      inflight_q <= inflight_d;
      for (int b = 0; b < 2; b++) begin
        wptr_q[b]   <= wptr_d[b];
        rptr_q[b]   <= rptr_d[b];
        cnt_q[b]    <= cnt_d[b];
        credit_q[b] <= credit_d[b];
      end
    end
  end

  for (genvar gb = 0; gb < 2; gb++) begin : g_chk
    // A dequeue from an already-empty small FIFO means the consumer is out of sync.
    credit_overflow_a: assert property (@(posedge clk_i) disable iff (reset_i)
        !(sf_deq_i[gb] && (credit_q[gb] == 2'd2)));
  end

endmodule
